// File: rtl/sid_mixer_pkg.sv
// Shared constants and types for the SID voice-routing / output-mixing stage.
package sid_mixer_pkg;

   localparam int unsigned W       = 16;
   localparam int unsigned ACC_W   = 19;
   localparam int unsigned NUM_SRC = 7;

   localparam logic signed [W-1:0] DIGI_DC = 16'sh0800;

   localparam logic [4:0] ADDR_FILT = 5'h17;
   localparam logic [4:0] ADDR_MODE = 5'h18;

   localparam logic [2:0] SRC_V1  = 3'd0;
   localparam logic [2:0] SRC_V2  = 3'd1;
   localparam logic [2:0] SRC_V3  = 3'd2;
   localparam logic [2:0] SRC_EXT = 3'd3;
   localparam logic [2:0] SRC_LP  = 3'd4;
   localparam logic [2:0] SRC_BP  = 3'd5;
   localparam logic [2:0] SRC_HP  = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC,
      ST_SCALE,
      ST_OUT
   } state_e;

endpackage

// File: rtl/sid_mixer_if.sv
// Audio sample, register-write and mixed-output bundle of the SID mixer.
interface sid_mixer_if;
   import sid_mixer_pkg::*;

   logic                clkEn;
   logic signed [W-1:0] iV1;
   logic signed [W-1:0] iV2;
   logic signed [W-1:0] iV3;
   logic signed [W-1:0] iExt;
   logic signed [W-1:0] iLP;
   logic signed [W-1:0] iBP;
   logic signed [W-1:0] iHP;
   logic                iWE;
   logic [4:0]          iAddr;
   logic [7:0]          iData;
   logic signed [W-1:0] oFiltIn;
   logic signed [W-1:0] oOut;
   logic                oValid;

   modport slave (
      input  clkEn, iV1, iV2, iV3, iExt, iLP, iBP, iHP, iWE, iAddr, iData,
      output oFiltIn, oOut, oValid
   );

   modport master (
      output clkEn, iV1, iV2, iV3, iExt, iLP, iBP, iHP, iWE, iAddr, iData,
      input  oFiltIn, oOut, oValid
   );

endinterface

// File: rtl/sid_mixer_sat.sv
// Signed saturating narrower: clamps an IN_W-bit value into OUT_W bits.
module mixer_sat #(
   parameter int unsigned IN_W  = 19,
   parameter int unsigned OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  a_i,
   output logic signed [OUT_W-1:0] y_o
);

   localparam logic signed [IN_W-1:0] MAX_V = IN_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(2 ** (OUT_W - 1)));

   always_comb begin
      if (a_i > MAX_V) begin
         y_o = MAX_V[OUT_W-1:0];
      end else if (a_i < MIN_V) begin
         y_o = MIN_V[OUT_W-1:0];
      end else begin
         y_o = a_i[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/sid_mixer.sv
// SID voice router / output mixer: one time-shared accumulator sequenced per sample strobe.
// Optional SID_DIGI_EN adds a DC term ahead of the volume multiply (audible volume-write steps).
module sid_mixer
   import sid_mixer_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   sid_mixer_if.slave   bus_io
);

   state_e                  state_q, state_d;
   logic [2:0]              idx_q, idx_d;
   logic signed [ACC_W-1:0] acc_f_q, acc_f_d;
   logic signed [ACC_W-1:0] acc_d_q, acc_d_d;
   logic signed [W-1:0]     src_q [NUM_SRC];
   logic signed [W-1:0]     src_d [NUM_SRC];
   logic [3:0]              reg_filt_q, reg_filt_d;
   logic [3:0]              reg_vol_q, reg_vol_d;
   logic [3:0]              reg_mode_q, reg_mode_d;
   logic [3:0]              filt_sh_q, filt_sh_d;
   logic [3:0]              vol_sh_q, vol_sh_d;
   logic [3:0]              mode_sh_q, mode_sh_d;
   logic signed [W-1:0]     y_q, y_d;
   logic signed [W-1:0]     out_q, out_d;
   logic signed [W-1:0]     fin_q, fin_d;
   logic                    valid_q, valid_d;

   logic signed [W-1:0]     sd_c;
   logic signed [W-1:0]     sdv_c;
   logic signed [W-1:0]     y_c;
   logic signed [W-1:0]     acc_f_sat_c;
   logic signed [4:0]       vol_s_c;
   logic signed [W+4:0]     prod_c;
   logic signed [W+4:0]     prod_sh_c;
   logic signed [ACC_W-1:0] term_c;

   mixer_sat #(.IN_W(ACC_W), .OUT_W(W)) u_sat_d (.a_i(acc_d_q), .y_o(sd_c));
   mixer_sat #(.IN_W(ACC_W), .OUT_W(W)) u_sat_f (.a_i(acc_f_q), .y_o(acc_f_sat_c));

`ifdef SID_DIGI_EN
   logic signed [ACC_W-1:0] dc_sum_c;
   assign dc_sum_c = ACC_W'(sd_c) + ACC_W'(DIGI_DC);
   mixer_sat #(.IN_W(ACC_W), .OUT_W(W)) u_sat_dc (.a_i(dc_sum_c), .y_o(sdv_c));
`else
   assign sdv_c = sd_c;
`endif

   // Volume is an unsigned 4-bit gain in 1/16 steps
   assign vol_s_c   = $signed({1'b0, vol_sh_q});
   assign prod_c    = (W+5)'(sdv_c) * (W+5)'(vol_s_c);
   assign prod_sh_c = prod_c >>> 4;

   mixer_sat #(.IN_W(W+5), .OUT_W(W)) u_sat_y (.a_i(prod_sh_c), .y_o(y_c));

   assign term_c = ACC_W'(src_q[idx_q]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         acc_f_q    <= '0;
         acc_d_q    <= '0;
         for (int i = 0; i < NUM_SRC; i++) src_q[i] <= '0;
         reg_filt_q <= '0;
         reg_vol_q  <= '0;
         reg_mode_q <= '0;
         filt_sh_q  <= '0;
         vol_sh_q   <= '0;
         mode_sh_q  <= '0;
         y_q        <= '0;
         out_q      <= '0;
         fin_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_f_q    <= acc_f_d;
         acc_d_q    <= acc_d_d;
         for (int i = 0; i < NUM_SRC; i++) src_q[i] <= src_d[i];
         reg_filt_q <= reg_filt_d;
         reg_vol_q  <= reg_vol_d;
         reg_mode_q <= reg_mode_d;
         filt_sh_q  <= filt_sh_d;
         vol_sh_q   <= vol_sh_d;
         mode_sh_q  <= mode_sh_d;
         y_q        <= y_d;
         out_q      <= out_d;
         fin_q      <= fin_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_f_d    = acc_f_q;
      acc_d_d    = acc_d_q;
      for (int i = 0; i < NUM_SRC; i++) src_d[i] = src_q[i];
      reg_filt_d = reg_filt_q;
      reg_vol_d  = reg_vol_q;
      reg_mode_d = reg_mode_q;
      filt_sh_d  = filt_sh_q;
      vol_sh_d   = vol_sh_q;
      mode_sh_d  = mode_sh_q;
      y_d        = y_q;
      out_d      = out_q;
      fin_d      = fin_q;
      valid_d    = 1'b0;

      if (bus_io.iWE) begin
         if (bus_io.iAddr == ADDR_FILT) begin
            reg_filt_d = bus_io.iData[3:0];
         end else if (bus_io.iAddr == ADDR_MODE) begin
            reg_vol_d  = bus_io.iData[3:0];
            reg_mode_d = bus_io.iData[7:4];
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (bus_io.clkEn) begin
               src_d[SRC_V1]  = bus_io.iV1;
               src_d[SRC_V2]  = bus_io.iV2;
               src_d[SRC_V3]  = bus_io.iV3;
               src_d[SRC_EXT] = bus_io.iExt;
               src_d[SRC_LP]  = bus_io.iLP;
               src_d[SRC_BP]  = bus_io.iBP;
               src_d[SRC_HP]  = bus_io.iHP;
               filt_sh_d      = reg_filt_q;
               vol_sh_d       = reg_vol_q;
               mode_sh_d      = reg_mode_q;
               acc_f_d        = '0;
               acc_d_d        = '0;
               idx_d          = SRC_V1;
               state_d        = ST_ACC;
            end
         end
         ST_ACC: begin
            // Voices/ext go to filter or direct path; V3 direct path muted by 3OFF
            if (!idx_q[2]) begin
               if (filt_sh_q[idx_q[1:0]]) begin
                  acc_f_d = acc_f_q + term_c;
               end else if (!((idx_q == SRC_V3) && mode_sh_q[3])) begin
                  acc_d_d = acc_d_q + term_c;
               end
            end else if (mode_sh_q[idx_q[1:0]]) begin
               acc_d_d = acc_d_q + term_c;
            end
            if (idx_q == SRC_HP) begin
               state_d = ST_SCALE;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         ST_SCALE: begin
            y_d     = y_c;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            out_d   = y_q;
            fin_d   = acc_f_sat_c;
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus_io.oOut    = out_q;
   assign bus_io.oFiltIn = fin_q;
   assign bus_io.oValid  = valid_q;

endmodule
